// File: rtl/calc_rr_scheduler_if.sv
// Requester fabric bundle for calc_rr_scheduler: per-requester request
// channels plus the shared, id-tagged response channel.
interface calc_rr_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned DW    = 32
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_data;
    logic [ID_W-1:0]     rsp_id;

    // Requester fabric side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/calc_rr_scheduler.sv
// calc_rr_scheduler: round-robin sharing of one calculate_2 core between
// N_REQ requesters. One operation in flight: IDLE (grant) -> ISSUE (start
// until done) -> RESP (hold result until accepted).
// Optional feature macro CALC_SCHED_KEY_REG_EN: locking_key becomes a register
// loaded from key_in on key_wr while IDLE; otherwise key_in passes through.
module calc_rr_scheduler #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ),
    parameter int unsigned DW    = 32,
    parameter int unsigned KEY_W = 255
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    calc_rr_scheduler_if.slave  bus,
    output logic                calc_ap_start,
    input  logic                calc_ap_done,
    input  logic                calc_ap_ready,
    output logic [DW-1:0]       calc_a,
    output logic [DW-1:0]       calc_b,
    input  logic [DW-1:0]       calc_ap_return,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                key_wr,
    output logic [KEY_W-1:0]    locking_key
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              start_q, start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;

    logic              grant_vld_c;
    logic [ID_W-1:0]   grant_id_c;
    logic [DW-1:0]     sel_a_c;
    logic [DW-1:0]     sel_b_c;
    logic [ID_W-1:0]   idx_c;
    logic              unused_sig;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        idx_c       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx_c = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld_c && bus.req_valid[idx_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = idx_c;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id_c == ID_W'(i)) begin
                sel_a_c = bus.req_a[i*DW +: DW];
                sel_b_c = bus.req_b[i*DW +: DW];
            end
        end
    end

    // One-cycle grant pulse, only while IDLE and out of reset.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == ST_IDLE && grant_vld_c && !ap_rst) begin
            bus.req_ready[grant_id_c] = 1'b1;
        end
    end

    // Next-state and register update for the scheduling FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        start_d     = start_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    a_d      = sel_a_c;
                    b_d      = sel_b_c;
                    cur_id_d = grant_id_c;
                    rr_ptr_d = grant_id_c;
                    start_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (calc_ap_done) begin
                    start_d     = 1'b0;
                    rsp_data_d  = calc_ap_return;
                    rsp_id_d    = cur_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                start_d     = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            cur_id_q    <= '0;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_id_q    <= cur_id_d;
            start_q     <= start_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign calc_ap_start = start_q;
    assign calc_a        = a_q;
    assign calc_b        = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef CALC_SCHED_KEY_REG_EN
    logic [KEY_W-1:0] key_q, key_d;

    // Key loads only between operations so the core never sees it change mid-op.
    always_comb begin
        key_d = key_q;
        if (key_wr && state_q == ST_IDLE) begin
            key_d = key_in;
        end
    end

    // Key register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign locking_key = key_q;
    assign unused_sig  = calc_ap_ready;
`else
    assign locking_key = key_in;
    assign unused_sig  = calc_ap_ready ^ key_wr;
`endif

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// Self-checking bench for calc_rr_scheduler with a stub core
// (ap_return = a + b, done after stub_d cycles of start).
module tb_calc_rr_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned KEY_W = 255;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             calc_ap_start;
    logic             calc_ap_done;
    logic             calc_ap_ready;
    logic [DW-1:0]    calc_a;
    logic [DW-1:0]    calc_b;
    logic [DW-1:0]    calc_ap_return;
    logic [KEY_W-1:0] key_in;
    logic             key_wr;
    logic [KEY_W-1:0] locking_key;

    logic [DW-1:0]    op_a [N_REQ];
    logic [DW-1:0]    op_b [N_REQ];
    int               stub_d;
    int               stub_cnt;

    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    int               m_ptr  = N_REQ - 1;
    int               sb_id   [$];
    logic [DW-1:0]    sb_data [$];
    int               grant_log [$];
    int               grant_cyc [$];

    calc_rr_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DW(DW)) bus ();

    calc_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .DW(DW), .KEY_W(KEY_W)) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .bus            (bus),
        .calc_ap_start  (calc_ap_start),
        .calc_ap_done   (calc_ap_done),
        .calc_ap_ready  (calc_ap_ready),
        .calc_a         (calc_a),
        .calc_b         (calc_b),
        .calc_ap_return (calc_ap_return),
        .key_in         (key_in),
        .key_wr         (key_wr),
        .locking_key    (locking_key)
    );

    always #5 ap_clk = ~ap_clk;

    // Pack bench operands into the request buses.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_a[i*DW +: DW] = op_a[i];
            bus.req_b[i*DW +: DW] = op_b[i];
        end
    end

    // Stub core.
    always @(posedge ap_clk) begin
        if (!calc_ap_start) stub_cnt <= 0;
        else if (!calc_ap_done) stub_cnt <= stub_cnt + 1;
    end
    assign calc_ap_done   = calc_ap_start && (stub_cnt == stub_d);
    assign calc_ap_ready  = calc_ap_done;
    assign calc_ap_return = calc_a + calc_b;

    // Scoreboard: round-robin model predicts each grant and pushes the expected
    // response; every accepted response is popped and compared.
    always @(negedge ap_clk) begin : monitor
        int      eg;
        bit      found;
        logic [N_REQ-1:0] exp_rdy;
        cyc++;
        if (ap_rst) begin
            sb_id.delete();
            sb_data.delete();
            m_ptr = N_REQ - 1;
        end else begin
            if (bus.req_ready !== '0) begin
                found = 1'b0;
                eg    = 0;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!found && bus.req_valid[(m_ptr + k) % N_REQ]) begin
                        found = 1'b1;
                        eg    = (m_ptr + k) % N_REQ;
                    end
                end
                exp_rdy = '0;
                if (found) exp_rdy[eg] = 1'b1;
                checks++;
                if (bus.req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL rr_grant: req_ready got %b want %b", bus.req_ready, exp_rdy);
                end
                m_ptr = eg;
                sb_id.push_back(eg);
                sb_data.push_back(op_a[eg] + op_b[eg]);
                grant_log.push_back(eg);
                grant_cyc.push_back(cyc);
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                checks++;
                if (sb_id.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: rsp id %0d data %0h with nothing expected",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    if (32'(bus.rsp_id) !== sb_id[0] || bus.rsp_data !== sb_data[0]) begin
                        errors++;
                        $display("FAIL sb_rsp: got id %0d data %0h want id %0d data %0h",
                                 bus.rsp_id, bus.rsp_data, sb_id[0], sb_data[0]);
                    end
                    void'(sb_id.pop_front());
                    void'(sb_data.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst        = 1'b1;
        bus.req_valid = '1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (bus.req_ready !== '0) begin
            errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_id !== '0) begin
            errors++; $display("FAIL rst_rsp: got v%b d%0h id%0d want 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        end
        checks++;
        if (calc_ap_start !== 1'b0 || calc_a !== '0 || calc_b !== '0) begin
            errors++; $display("FAIL rst_core: got start %b a %0h b %0h want 0", calc_ap_start, calc_a, calc_b);
        end
`ifdef CALC_SCHED_KEY_REG_EN
        checks++;
        if (locking_key !== '0) begin
            errors++; $display("FAIL rst_key: got %0h want 0", locking_key);
        end
`endif
        tick();
        bus.req_valid = '0;
        ap_rst        = 1'b0;
    endtask

    task automatic test_single();
        stub_d        = 0;
        bus.rsp_ready = 1'b1;
        tick();
        op_a[0] = 32'd5;
        op_b[0] = 32'd7;
        bus.req_valid = 4'b0001;
        @(negedge ap_clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL t1_grant: got %b want 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        @(negedge ap_clk);
        checks++;
        if (calc_ap_start !== 1'b1 || calc_a !== 32'd5 || calc_b !== 32'd7 || bus.req_ready !== '0) begin
            errors++; $display("FAIL t1_issue: got start %b a %0d b %0d rdy %b want 1 5 7 0",
                               calc_ap_start, calc_a, calc_b, bus.req_ready);
        end
        @(negedge ap_clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_id !== 2'd0) begin
            errors++; $display("FAIL t1_resp: got v%b d%0d id%0d want 1 12 0",
                               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
        end
        checks++;
        if (calc_ap_start !== 1'b0) begin
            errors++; $display("FAIL t1_start_drop: got %b want 0", calc_ap_start);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        stub_d        = 0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            if (grant_log.size() >= 5) break;
        end
        tick();
        bus.req_valid = '0;
        checks++;
        if (grant_log.size() < 5) begin
            errors++; $display("FAIL t2_timeout: got %0d grants want 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (grant_log[i] !== exp_order[i]) begin
                    errors++; $display("FAIL t2_order[%0d]: got %0d want %0d", i, grant_log[i], exp_order[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (grant_cyc[i] - grant_cyc[i-1] !== 3) begin
                    errors++; $display("FAIL t2_gap[%0d]: got %0d want 3", i, grant_cyc[i] - grant_cyc[i-1]);
                end
            end
        end
        for (int c = 0; c < 20 && (sb_id.size() != 0 || bus.rsp_valid === 1'b1); c++) @(negedge ap_clk);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        int            n_before;
        bit            seen;
        op_a[2] = $urandom;
        op_b[2] = $urandom;
        exp     = op_a[2] + op_b[2];
        stub_d  = 0;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.req_ready !== '0);
        end
        tick();
        bus.req_valid = '1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.rsp_valid === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL t3_no_rsp: rsp_valid got 0 want 1");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.rsp_id !== 2'd2 || bus.req_ready !== '0) begin
                errors++; $display("FAIL t3_hold[%0d]: got v%b d%0h id%0d rdy%b want 1 %0h 2 0",
                                   c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, exp);
            end
        end
        n_before = grant_log.size();
        tick();
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.req_ready !== '0);
        end
        tick();
        bus.req_valid = '0;
        checks++;
        if (grant_log.size() != n_before + 1 || grant_log[grant_log.size()-1] != 3) begin
            errors++; $display("FAIL t3_next_grant: got %0d grants want one grant to 3", grant_log.size() - n_before);
        end
        for (int c = 0; c < 20 && (sb_id.size() != 0 || bus.rsp_valid === 1'b1); c++) @(negedge ap_clk);
    endtask

    task automatic test_long_latency();
        int n_start;
        bit seen;
        stub_d = 3;
        tick();
        bus.rsp_ready = 1'b1;
        op_a[1] = 32'hFFFF_FFFF;
        op_b[1] = 32'h0000_0001;
        bus.req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.req_ready === 4'b0010);
        end
        tick();
        bus.req_valid = '0;
        n_start = 0;
        seen    = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge ap_clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
            else if (calc_ap_start === 1'b1) n_start++;
        end
        checks++;
        if (n_start != 4) begin
            errors++; $display("FAIL t4_start_len: got %0d want 4", n_start);
        end
        checks++;
        if (!seen || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd1) begin
            errors++; $display("FAIL t4_resp: got v%b d%0h id%0d want 1 0 1", seen, bus.rsp_data, bus.rsp_id);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        stub_d = 3;
        op_a[3] = $urandom;
        op_b[3] = $urandom;
        op_a[0] = $urandom;
        op_b[0] = $urandom;
        tick();
        bus.req_valid = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.req_ready !== '0);
        end
        tick();
        bus.req_valid = '0;
        @(negedge ap_clk);
        checks++;
        if (calc_ap_start !== 1'b1) begin
            errors++; $display("FAIL t5_in_issue: start got %b want 1", calc_ap_start);
        end
        tick();
        ap_rst        = 1'b1;
        bus.req_valid = '1;
        tick();
        @(negedge ap_clk);
        checks++;
        if (calc_ap_start !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
            errors++; $display("FAIL t5_abort: got start %b rsp_valid %b rdy %b want 0 0 0",
                               calc_ap_start, bus.rsp_valid, bus.req_ready);
        end
        tick();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++; $display("FAIL t5_first_grant: got %b want 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        for (int c = 0; c < 30 && (sb_id.size() != 0 || bus.rsp_valid === 1'b1); c++) @(negedge ap_clk);
    endtask

    task automatic test_key();
        logic [KEY_W-1:0] k55;
        logic [KEY_W-1:0] krnd;
        for (int i = 0; i < int'(KEY_W); i++) begin
            k55[i]  = (i % 2 == 0);
            krnd[i] = 1'($urandom_range(0, 1));
        end
`ifdef CALC_SCHED_KEY_REG_EN
        bit seen;
        tick();
        key_in = k55;
        key_wr = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (locking_key !== '0) begin
            errors++; $display("FAIL t6_key_early: got %0h want 0", locking_key);
        end
        tick();
        key_wr = 1'b0;
        key_in = krnd;
        @(negedge ap_clk);
        checks++;
        if (locking_key !== k55) begin
            errors++; $display("FAIL t6_key_load: got %0h want %0h", locking_key, k55);
        end
        stub_d = 3;
        tick();
        bus.req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge ap_clk);
            seen = (bus.req_ready !== '0);
        end
        tick();
        bus.req_valid = '0;
        tick();
        key_in = ~k55;
        key_wr = 1'b1;
        tick();
        key_wr = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (locking_key !== k55 || calc_ap_start !== 1'b1) begin
            errors++; $display("FAIL t6_key_issue: got %0h start %b want %0h start 1", locking_key, calc_ap_start, k55);
        end
        for (int c = 0; c < 30 && (sb_id.size() != 0 || bus.rsp_valid === 1'b1); c++) @(negedge ap_clk);
`else
        tick();
        key_in = k55;
        key_wr = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (locking_key !== k55) begin
            errors++; $display("FAIL key_pass_a: got %0h want %0h", locking_key, k55);
        end
        tick();
        key_in = krnd;
        key_wr = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (locking_key !== krnd) begin
            errors++; $display("FAIL key_pass_b: got %0h want %0h", locking_key, krnd);
        end
        tick();
        key_wr = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        stub_d        = 0;
        key_in        = '0;
        key_wr        = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_long_latency();
        test_reset_mid();
        test_key();

        checks++;
        if (sb_id.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d outstanding want 0", sb_id.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
